// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Results are held in a single response register with valid/ready flow control.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_op,
    output logic             req1_ready,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_op,
    input  logic [31:0]      alu_res,
    input  logic             alu_int_ov,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [31:0]      rsp_res,
    output logic             rsp_ov,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr;
    logic             w_rr_nxt;
    logic             w_can_accept;
    logic             w_any_valid;
    logic             w_gnt;
    logic             w_accept;
    logic             r_rsp_id;
    logic [31:0]      r_rsp_res;
    logic             r_rsp_ov;
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;

    // The overflow flag only carries meaning for add and subtract.
    function automatic logic ov_qualify(input logic [4:0] op, input logic ov);
        logic q;
        if ((op == 5'b00001) || (op == 5'b01001)) begin
            q = ov;
        end else begin
            q = 1'b0;
        end
        return q;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] n;
        if (cnt == {CNT_W{1'b1}}) begin
            n = cnt;
        end else begin
            n = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Arbitration, ALU operand steering, handshakes and next-state logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_any_valid  = req0_valid || req1_valid;
        w_can_accept = (r_state == EMPTY) || rsp_ready;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_op       = 5'b00000;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt = r_rr;
        end else begin
            w_gnt = req1_valid;
        end
        w_accept = w_can_accept && w_any_valid;

        case ({w_any_valid, w_gnt})
            2'b10: begin
                alu_a  = req0_a;
                alu_b  = req0_b;
                alu_op = req0_op;
            end
            2'b11: begin
                alu_a  = req1_a;
                alu_b  = req1_b;
                alu_op = req1_op;
            end
            default: begin
                alu_a  = 32'd0;
                alu_b  = 32'd0;
                alu_op = 5'b00000;
            end
        endcase

        if (w_accept) begin
            req0_ready = ~w_gnt;
            req1_ready = w_gnt;
            w_rr_nxt   = ~w_gnt;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            w_rr_nxt   = r_rr;
        end

        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = EMPTY;
                end else begin
                    w_state_nxt = FULL;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Response payload; it holds its last value once drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_id  <= 1'b0;
            r_rsp_res <= 32'd0;
            r_rsp_ov  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_id  <= w_gnt;
            r_rsp_res <= alu_res;
            r_rsp_ov  <= ov_qualify(alu_op, alu_int_ov);
        end else begin
            r_rsp_id  <= r_rsp_id;
            r_rsp_res <= r_rsp_res;
            r_rsp_ov  <= r_rsp_ov;
        end
    end

    // Saturating per-requester acceptance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_cnt0 <= {CNT_W{1'b0}};
            r_gnt_cnt1 <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            if (w_gnt) begin
                r_gnt_cnt1 <= sat_inc(r_gnt_cnt1);
            end else begin
                r_gnt_cnt0 <= sat_inc(r_gnt_cnt0);
            end
        end else begin
            r_gnt_cnt0 <= r_gnt_cnt0;
            r_gnt_cnt1 <= r_gnt_cnt1;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_ov    = r_rsp_ov;
    assign gnt_cnt0  = r_gnt_cnt0;
    assign gnt_cnt1  = r_gnt_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model;
// a 16-bit-counter and a 4-bit-counter instance share the same stimulus.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;

    logic        d_r0, d_r1, d_rv, d_rid, d_rov, d_ov;
    logic [31:0] d_a, d_b, d_res, d_rres;
    logic [4:0]  d_op;
    logic [15:0] d_c0, d_c1;

    logic        s_r0, s_r1, s_rv, s_rid, s_rov, s_ov;
    logic [31:0] s_a, s_b, s_res, s_rres;
    logic [4:0]  s_op;
    logic [3:0]  s_c0, s_c1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference ALU: bit 32 is the carry/borrow/shift-out flag.
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        logic [32:0] r;
        case (op)
            5'b00001: r = {1'b0, a} + {1'b0, b};
            5'b01001: r = {1'b0, a} - {1'b0, b};
            5'b00100: r = {1'b0, a} << b[4:0];
            default:  r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    assign {d_ov, d_res} = alu_f(d_a, d_b, d_op);
    assign {s_ov, s_res} = alu_f(s_a, s_b, s_op);

    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(d_r0),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(d_r1),
        .alu_a(d_a), .alu_b(d_b), .alu_op(d_op), .alu_res(d_res), .alu_int_ov(d_ov),
        .rsp_valid(d_rv), .rsp_id(d_rid), .rsp_res(d_rres), .rsp_ov(d_rov),
        .rsp_ready(rsp_ready), .gnt_cnt0(d_c0), .gnt_cnt1(d_c1)
    );

    alu_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(s_r1),
        .alu_a(s_a), .alu_b(s_b), .alu_op(s_op), .alu_res(s_res), .alu_int_ov(s_ov),
        .rsp_valid(s_rv), .rsp_id(s_rid), .rsp_res(s_rres), .rsp_ov(s_rov),
        .rsp_ready(rsp_ready), .gnt_cnt0(s_c0), .gnt_cnt1(s_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: one response slot, a pointer, unbounded acceptance counts.
    logic        m_valid = 1'b0;
    logic        m_id    = 1'b0;
    logic [31:0] m_res   = 32'd0;
    logic        m_ov    = 1'b0;
    logic        m_rr    = 1'b0;
    int          m_cnt0  = 0;
    int          m_cnt1  = 0;

    logic        e_can, e_any, e_g, e_r0, e_r1;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_op;
    logic [32:0] e_r;

    always_comb begin
        e_can = !m_valid || rsp_ready;
        e_any = req0_valid || req1_valid;
        e_g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
        e_r0  = e_can && e_any && !e_g;
        e_r1  = e_can && e_any && e_g;
        e_a   = !e_any ? 32'd0 : (e_g ? req1_a : req0_a);
        e_b   = !e_any ? 32'd0 : (e_g ? req1_b : req0_b);
        e_op  = !e_any ? 5'd0 : (e_g ? req1_op : req0_op);
        e_r   = alu_f(e_a, e_b, e_op);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0; m_id <= 1'b0; m_res <= 32'd0; m_ov <= 1'b0; m_rr <= 1'b0;
            m_cnt0  <= 0;    m_cnt1 <= 0;
        end else if (e_can && e_any) begin
            m_valid <= 1'b1;
            m_id    <= e_g;
            m_res   <= e_r[31:0];
            m_ov    <= ((e_op == 5'b00001) || (e_op == 5'b01001)) ? e_r[32] : 1'b0;
            m_rr    <= !e_g;
            if (e_g) m_cnt1 <= m_cnt1 + 1;
            else     m_cnt0 <= m_cnt0 + 1;
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("req0_ready", d_r0, e_r0);
        check("req1_ready", d_r1, e_r1);
        check("alu_a", d_a, e_a);
        check("alu_b", d_b, e_b);
        check("alu_op", d_op, e_op);
        check("rsp_valid", d_rv, m_valid);
        check("rsp_id", d_rid, m_id);
        check("rsp_res", d_rres, m_res);
        check("rsp_ov", d_rov, m_ov);
        check("gnt_cnt0", d_c0, sat(m_cnt0, 65535));
        check("gnt_cnt1", d_c1, sat(m_cnt1, 65535));
        check("w4_ready0", s_r0, e_r0);
        check("w4_ready1", s_r1, e_r1);
        check("w4_rsp_valid", s_rv, m_valid);
        check("w4_rsp_res", s_rres, m_res);
        check("w4_gnt_cnt0", s_c0, sat(m_cnt0, 15));
        check("w4_gnt_cnt1", s_c1, sat(m_cnt1, 15));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 5'd0;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 5'd0;
    endtask

    function automatic logic [4:0] rnd_op();
        logic [4:0] ops [4];
        ops[0] = 5'b00001; ops[1] = 5'b01001; ops[2] = 5'b00100; ops[3] = 5'($urandom);
        return ops[$urandom_range(3, 0)];
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v [4];
        v[0] = 32'hFFFF_FFFF; v[1] = 32'h7FFF_FFFF; v[2] = 32'($urandom_range(7, 0));
        v[3] = 32'($urandom);
        return v[$urandom_range(3, 0)];
    endfunction

    int exp_g;

    initial begin
        reset = 1'b0;
        rsp_ready = 1'b1;
        idle();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 5'b00001;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 5'b01001;
        repeat (2) @(posedge clk);
        #1;
        check("lit_reset_rsp_valid", d_rv, 64'd0);
        reset = 1'b1;

        // Tie at reset release: req0 first, then req1.
        cyc();
        check("lit_c1_id", d_rid, 64'd0);
        check("lit_c1_res", d_rres, 64'd8);
        check("lit_c1_valid", d_rv, 64'd1);
        cyc();
        check("lit_c2_id", d_rid, 64'd1);
        check("lit_c2_res", d_rres, 64'd5);
        check("lit_c2_cnt0", d_c0, 64'd1);
        check("lit_c2_cnt1", d_c1, 64'd1);
        idle();
        cyc();

        // Overflow qualification.
        req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = 5'b00001;
        cyc();
        check("lit_add_res", d_rres, 64'h8000_0000);
        check("lit_add_ov", d_rov, 64'd0);
        req0_a = 32'hFFFF_FFFF;
        cyc();
        check("lit_carry_res", d_rres, 64'd0);
        check("lit_carry_ov", d_rov, 64'd1);
        req0_a = 32'h8000_0000; req0_op = 5'b00100;
        #1;
        check("lit_shift_alu_ov", d_ov, 64'd1);
        cyc();
        check("lit_shift_res", d_rres, 64'd0);
        check("lit_shift_ov", d_rov, 64'd0);
        idle();
        cyc();

        // Backpressure holds everything; release grants the rr requester.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 5'b00001;
        cyc();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd40; req1_b = 32'd2; req1_op = 5'b01001;
        for (int i = 0; i < 5; i++) begin
            req0_a = $urandom;
            cyc();
            check("lit_bp_ready0", d_r0, 64'd0);
            check("lit_bp_ready1", d_r1, 64'd0);
            check("lit_bp_res", d_rres, 64'd3);
            check("lit_bp_valid", d_rv, 64'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("lit_bp_rel_ready1", d_r1, 64'd1);
        check("lit_bp_rel_ready0", d_r0, 64'd0);
        cyc();
        check("lit_bp_rel_res", d_rres, 64'd38);

        // Continuous contention alternates grants.
        exp_g = 0;
        for (int i = 0; i < 10; i++) begin
            check("lit_alt_ready0", d_r0, (exp_g == 0) ? 64'd1 : 64'd0);
            check("lit_alt_ready1", d_r1, (exp_g == 1) ? 64'd1 : 64'd0);
            cyc();
            check("lit_alt_valid", d_rv, 64'd1);
            check("lit_alt_id", d_rid, 64'(exp_g));
            exp_g = 1 - exp_g;
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(3, 0) != 0);
            req1_valid = ($urandom_range(3, 0) != 0);
            req0_a = rnd_val(); req0_b = rnd_val(); req0_op = rnd_op();
            req1_a = rnd_val(); req1_b = rnd_val(); req1_op = rnd_op();
            rsp_ready = ($urandom_range(2, 0) != 0);
            cyc();
        end

        // Counter saturation from a clean reset.
        idle();
        rsp_ready = 1'b1;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 5'b00001;
        for (int i = 0; i < 20; i++) cyc();
        check("lit_sat_w4_cnt0", s_c0, 64'd15);
        check("lit_sat_w16_cnt0", d_c0, 64'd20);
        check("lit_sat_w4_cnt1", s_c1, 64'd0);

        // Asynchronous reset while a response is held.
        req0_a = 32'd5; req0_b = 32'd3;
        cyc();
        rsp_ready = 1'b0;
        idle();
        check("lit_pre_arst_res", d_rres, 64'd8);
        check("lit_pre_arst_valid", d_rv, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("lit_arst_valid", d_rv, 64'd0);
        check("lit_arst_res", d_rres, 64'd0);
        check("lit_arst_id", d_rid, 64'd0);
        check("lit_arst_ov", d_rov, 64'd0);
        check("lit_arst_cnt0", d_c0, 64'd0);
        check("lit_arst_w4_cnt0", s_c0, 64'd0);
        cyc();
        reset = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_op = 5'b01001;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 5'b00001;
        cyc();
        check("lit_post_arst_id", d_rid, 64'd0);
        check("lit_post_arst_res", d_rres, 64'd6);
        idle();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
